// File: rtl/impulse_capture_avg.sv
// Impulse-response capture engine: fires a single-sample impulse, skips a delay,
// then accumulates 2^LOG2_AVG capture passes in RAM and serves the averaged response.
module impulse_capture_avg #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 4096,
    parameter int               ADDR_W      = $clog2(DEPTH),
    parameter int               LOG2_AVG    = 2,
    parameter logic [WIDTH-1:0] IMPULSE_AMP = 16'h7FFF
) (
    input  logic                audio_clk,
    input  logic                rst_in,
    input  logic                audio_trigger,
    input  logic                start_in,
    input  logic                abort_in,
    input  logic [ADDR_W:0]     impulse_length,
    input  logic [15:0]         delay_length,
    input  logic [WIDTH-1:0]    audio_in,
    output logic [WIDTH-1:0]    impulse_amp_out,
    output logic                busy_out,
    output logic [LOG2_AVG:0]   pass_out,
    output logic                done_out,
    input  logic [ADDR_W-1:0]   rd_addr_in,
    output logic [WIDTH-1:0]    rd_data_out
);

    localparam int                ACC_W     = WIDTH + LOG2_AVG;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [LOG2_AVG:0] PASS_LAST = (LOG2_AVG+1)'((1 << LOG2_AVG) - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRE   = 3'd1,
        S_DELAY  = 3'd2,
        S_RECORD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                    state_r;
    logic [ADDR_W:0]           len_r;
    logic [15:0]               dly_r;
    logic [15:0]               dly_cnt_r;
    logic [ADDR_W:0]           cap_cnt_r;
    logic [WIDTH-1:0]          amp_r;
    logic                      busy_r;
    logic [LOG2_AVG:0]         pass_r;
    logic                      done_r;

    logic                      v1_r;
    logic                      v2_r;
    logic                      first1_r;
    logic signed [WIDTH-1:0]   sample_r;
    logic [ADDR_W-1:0]         wr_addr1_r;
    logic [ADDR_W-1:0]         wr_addr2_r;
    logic signed [ACC_W-1:0]   wr_data_r;

    logic [ACC_W-1:0]          mem_r [DEPTH];
    logic signed [ACC_W-1:0]   ram_q_r;
    logic [WIDTH-1:0]          rd_data_r;

    logic                      cap_s;
    logic                      last_wr_s;
    logic [ADDR_W:0]           len_clamp_s;
    logic [ADDR_W-1:0]         ram_raddr_s;
    logic signed [ACC_W-1:0]   sext_s;
    logic signed [ACC_W-1:0]   avg_s;

    assign sext_s    = ACC_W'(sample_r);
    assign avg_s     = ram_q_r >>> LOG2_AVG;
    assign last_wr_s = v2_r && ({1'b0, wr_addr2_r} == (len_r - (ADDR_W+1)'(1)));

    // Capture strobe and shared read-port address (capture RMW wins over readback)
    always_comb begin
        cap_s       = 1'b0;
        ram_raddr_s = rd_addr_in;
        len_clamp_s = impulse_length;
        if (audio_trigger && (state_r == S_DELAY) && (dly_cnt_r == dly_r)) begin
            cap_s = 1'b1;
        end else if (audio_trigger && (state_r == S_RECORD) && (cap_cnt_r != len_r)) begin
            cap_s = 1'b1;
        end else begin
            cap_s = 1'b0;
        end
        if (cap_s) begin
            ram_raddr_s = cap_cnt_r[ADDR_W-1:0];
        end else begin
            ram_raddr_s = rd_addr_in;
        end
        if ((impulse_length == '0) || (impulse_length > DEPTH_L)) begin
            len_clamp_s = DEPTH_L;
        end else begin
            len_clamp_s = impulse_length;
        end
    end

    // Sequencer: impulse, delay, capture passes, completion
    always_ff @(posedge audio_clk) begin
        if (rst_in || abort_in) begin
            state_r   <= S_IDLE;
            amp_r     <= '0;
            busy_r    <= 1'b0;
            pass_r    <= '0;
            done_r    <= 1'b0;
            dly_cnt_r <= '0;
            cap_cnt_r <= '0;
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            if (rst_in) begin
                len_r <= '0;
                dly_r <= '0;
            end
        end else begin
            v1_r <= cap_s;
            v2_r <= v1_r;
            if (cap_s) begin
                cap_cnt_r <= cap_cnt_r + (ADDR_W+1)'(1);
            end
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_in) begin
                        len_r     <= len_clamp_s;
                        dly_r     <= delay_length;
                        pass_r    <= '0;
                        done_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        cap_cnt_r <= '0;
                        state_r   <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    if (audio_trigger) begin
                        amp_r     <= IMPULSE_AMP;
                        dly_cnt_r <= '0;
                        state_r   <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (audio_trigger) begin
                        amp_r <= '0;
                        if (dly_cnt_r == dly_r) begin
                            state_r <= S_RECORD;
                        end else begin
                            dly_cnt_r <= dly_cnt_r + 16'd1;
                        end
                    end
                end
                S_RECORD: begin
                    if (last_wr_s) begin
                        if (pass_r == PASS_LAST) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            pass_r    <= pass_r + (LOG2_AVG+1)'(1);
                            cap_cnt_r <= '0;
                            state_r   <= S_FIRE;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // RMW datapath: latch sample at the trigger, form the new accumulator a cycle later
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            sample_r   <= '0;
            first1_r   <= 1'b0;
            wr_addr1_r <= '0;
            wr_addr2_r <= '0;
            wr_data_r  <= '0;
        end else begin
            if (cap_s) begin
                sample_r   <= audio_in;
                first1_r   <= (pass_r == '0);
                wr_addr1_r <= cap_cnt_r[ADDR_W-1:0];
            end
            wr_addr2_r <= wr_addr1_r;
            wr_data_r  <= first1_r ? sext_s : (ram_q_r + sext_s);
        end
    end

    // Accumulator RAM write port, driven only by the RMW
    always_ff @(posedge audio_clk) begin
        if (v2_r && !abort_in && !rst_in) begin
            mem_r[wr_addr2_r] <= wr_data_r;
        end
    end

    // Shared read port and averaged readback register
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            ram_q_r   <= '0;
            rd_data_r <= '0;
        end else begin
            ram_q_r   <= mem_r[ram_raddr_s];
            rd_data_r <= avg_s[WIDTH-1:0];
        end
    end

    assign impulse_amp_out = amp_r;
    assign busy_out        = busy_r;
    assign pass_out        = pass_r;
    assign done_out        = done_r;
    assign rd_data_out     = rd_data_r;

endmodule

// File: tb/tb_impulse_capture_avg.sv
// Directed bench for impulse_capture_avg with a small accumulator model and
// scoreboard queues for impulse output and averaged readback.
module tb_impulse_capture_avg;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int LOG2_AVG = 2;
    localparam int NPASS    = 4;

    logic                audio_clk = 1'b0;
    logic                rst_in = 1'b1;
    logic                audio_trigger = 1'b0;
    logic                start_in = 1'b0;
    logic                abort_in = 1'b0;
    logic [ADDR_W:0]     impulse_length = '0;
    logic [15:0]         delay_length = '0;
    logic [WIDTH-1:0]    audio_in = '0;
    logic [WIDTH-1:0]    impulse_amp_out;
    logic                busy_out;
    logic [LOG2_AVG:0]   pass_out;
    logic                done_out;
    logic [ADDR_W-1:0]   rd_addr_in = '0;
    logic [WIDTH-1:0]    rd_data_out;

    int                  n_checks = 0;
    int                  n_fails  = 0;
    logic [WIDTH-1:0]    amp_q[$];
    logic [WIDTH-1:0]    rd_q[$];
    int                  exp_acc[DEPTH];

    impulse_capture_avg #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LOG2_AVG(LOG2_AVG),
        .IMPULSE_AMP(16'h7FFF)
    ) dut (
        .audio_clk(audio_clk), .rst_in(rst_in), .audio_trigger(audio_trigger),
        .start_in(start_in), .abort_in(abort_in), .impulse_length(impulse_length),
        .delay_length(delay_length), .audio_in(audio_in),
        .impulse_amp_out(impulse_amp_out), .busy_out(busy_out), .pass_out(pass_out),
        .done_out(done_out), .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out)
    );

    always #5 audio_clk = ~audio_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gen(input int mode, input int n);
        case (mode)
            0:       return n * 5 + 7;
            1:       return 100;
            2:       return -3;
            3:       return n * 37 - 300;
            4:       return 50 - n * 3;
            default: return 0;
        endcase
    endfunction

    task automatic do_start(input int len, input int dly);
        impulse_length = (ADDR_W+1)'(len);
        delay_length   = 16'(dly);
        start_in       = 1'b1;
        @(negedge audio_clk);
        start_in       = 1'b0;
        check("start_busy", 32'(busy_out), 32'd1);
        check("start_done", 32'(done_out), 32'd0);
        check("start_pass", 32'(pass_out), 32'd0);
    endtask

    task automatic pulse_trig(input int v, input logic [WIDTH-1:0] exp_amp, input int exp_pass);
        audio_in      = 16'(v);
        audio_trigger = 1'b1;
        amp_q.push_back(exp_amp);
        @(negedge audio_clk);
        audio_trigger = 1'b0;
        check("amp", 32'(impulse_amp_out), 32'(amp_q.pop_front()));
        check("pass", 32'(pass_out), 32'(exp_pass));
        repeat (3) @(negedge audio_clk);
    endtask

    task automatic run(input int len, input int dly, input int mode,
                       input bit inject_start, input int abort_at);
        int l_eff;
        int per;
        l_eff = ((len == 0) || (len > DEPTH)) ? DEPTH : len;
        per   = dly + l_eff + 1;
        do_start(len, dly);
        for (int n = 0; n < NPASS * per; n++) begin
            int p;
            int pos;
            int v;
            p   = n / per;
            pos = n % per;
            v   = gen(mode, n);
            if (pos > dly) begin
                exp_acc[pos - dly - 1] = (p == 0) ? v : exp_acc[pos - dly - 1] + v;
            end
            pulse_trig(v, (pos == 0) ? 16'h7FFF : 16'h0000, p);
            if (inject_start && (n == 1)) begin
                impulse_length = 5'd2;
                delay_length   = 16'd0;
                start_in       = 1'b1;
                @(negedge audio_clk);
                start_in       = 1'b0;
                check("inject_busy", 32'(busy_out), 32'd1);
            end
            if (n == abort_at) begin
                abort_in = 1'b1;
                @(negedge audio_clk);
                abort_in = 1'b0;
                check("abort_busy", 32'(busy_out), 32'd0);
                check("abort_done", 32'(done_out), 32'd0);
                check("abort_amp", 32'(impulse_amp_out), 32'd0);
                check("abort_pass", 32'(pass_out), 32'd0);
                return;
            end
        end
        @(negedge audio_clk);
        check("end_done", 32'(done_out), 32'd1);
        check("end_busy", 32'(busy_out), 32'd0);
        check("end_pass", 32'(pass_out), 32'(NPASS - 1));
        for (int a = 0; a < l_eff; a++) begin
            int avg;
            avg        = exp_acc[a] >>> LOG2_AVG;
            rd_addr_in = ADDR_W'(a);
            rd_q.push_back(16'(avg));
            @(negedge audio_clk);
            @(negedge audio_clk);
            check("rd_data", 32'(rd_data_out), 32'(rd_q.pop_front()));
        end
    endtask

    initial begin
        repeat (3) @(negedge audio_clk);
        check("rst_amp", 32'(impulse_amp_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_pass", 32'(pass_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_rd", 32'(rd_data_out), 32'd0);
        rst_in = 1'b0;
        @(negedge audio_clk);

        run(8, 3, 0, 1'b0, -1);
        run(4, 1, 1, 1'b1, -1);
        run(4, 1, 2, 1'b0, -1);
        run(0, 0, 3, 1'b0, -1);
        run(20, 2, 4, 1'b0, -1);

        start_in = 1'b1;
        abort_in = 1'b1;
        @(negedge audio_clk);
        start_in = 1'b0;
        abort_in = 1'b0;
        check("sa_done", 32'(done_out), 32'd0);
        check("sa_busy", 32'(busy_out), 32'd0);
        pulse_trig(1234, 16'h0000, 0);
        check("idle_busy", 32'(busy_out), 32'd0);

        run(4, 1, 0, 1'b0, 2 * 6 + 3);
        run(4, 1, 4, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
